// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage data-memory access controller:
// aluop encodings of the memory instructions, reset/write-enable levels,
// the zero word, the controller FSM state type and op-classification helpers.
// No ports (package).
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
      EXE_LW_OP, EXE_LL_OP:                 return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align
// Purely combinational byte-lane logic for a big-endian 32-bit data bus.
// Ports:
//   aluop      in  8   memory op code
//   addr       in  32  effective address (low two bits pick the lanes)
//   store_data in  32  rt value for stores
//   rdata      in  32  captured bus read word
//   sel        out 4   byte-lane select (bit 3 = bits [31:24])
//   wdata      out 32  store data replicated across the selected lanes
//   we         out 1   op writes memory
//   misalign   out 2   {load_misalign, store_misalign}
//   load_data  out 32  extracted and sign/zero-extended load result
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        we,
  output logic [1:0]  misalign,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Big-endian: the lowest address lives in the most significant lane.
  always_comb begin
    case (addr[1:0])
      2'b00:   rd_byte = rdata[31:24];
      2'b01:   rd_byte = rdata[23:16];
      2'b10:   rd_byte = rdata[15:8];
      default: rd_byte = rdata[7:0];
    endcase
    rd_half = addr[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata     = ZERO_WORD;
    we        = 1'b0;
    misalign  = 2'b00;
    load_data = ZERO_WORD;
    case (aluop)
      EXE_LB_OP: begin
        sel       = 4'b1000 >> addr[1:0];
        load_data = {{24{rd_byte[7]}}, rd_byte};
      end
      EXE_LBU_OP: begin
        sel       = 4'b1000 >> addr[1:0];
        load_data = {24'h0, rd_byte};
      end
      EXE_LH_OP: begin
        misalign[1] = addr[0];
        sel         = addr[1] ? 4'b0011 : 4'b1100;
        load_data   = {{16{rd_half[15]}}, rd_half};
      end
      EXE_LHU_OP: begin
        misalign[1] = addr[0];
        sel         = addr[1] ? 4'b0011 : 4'b1100;
        load_data   = {16'h0, rd_half};
      end
      EXE_LW_OP, EXE_LL_OP: begin
        misalign[1] = |addr[1:0];
        sel         = 4'b1111;
        load_data   = rdata;
      end
      EXE_SB_OP: begin
        we    = 1'b1;
        sel   = 4'b1000 >> addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        we          = 1'b1;
        misalign[0] = addr[0];
        sel         = addr[1] ? 4'b0011 : 4'b1100;
        wdata       = {2{store_data[15:0]}};
      end
      EXE_SW_OP, EXE_SC_OP: begin
        we          = 1'b1;
        misalign[0] = |addr[1:0];
        sel         = 4'b1111;
        wdata       = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory access controller. Runs loads, stores and LL/SC
// over a req/ack bus, stalls the pipeline until the bus acknowledges, and
// produces the MEM/WB results plus the LLbit write request.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abort any access in flight
//   aluop_i, mem_addr_i      op code and effective address from EX/MEM
//   reg2_i                   store data
//   wd_i, wreg_i, wdata_i    destination / ALU result from EX/MEM
//   LLbit_i                  committed LLbit
//   wb_LLbit_we_i/value_i    pending LLbit write in WB (forwarded)
//   dbus_*                   data bus (req held until single-cycle ack)
//   wd_o, wreg_o, wdata_o    results to MEM/WB
//   LLbit_we_o/value_o       LLbit write request to MEM/WB
//   misalign_o               {load_misalign, store_misalign}
//   stallreq_o               stall request to the pipeline controller
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we_i,
  input  logic              wb_LLbit_value_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  input  logic              dbus_ack_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_sel_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o,
  output logic [1:0]        misalign_o,
  output logic              stallreq_o
);

  state_t            state_reg;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_we;
  logic [1:0]        lane_misalign;
  logic [DATA_W-1:0] load_data;

  logic ll_eff;
  logic is_load;
  logic is_mem;
  logic misaligned;
  logic sc_fail;
  logic start;

  mem_lane_align u_lane_align (
    .aluop      (aluop_i),
    .addr       (mem_addr_i),
    .store_data (reg2_i),
    .rdata      (rdata_q),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .we         (lane_we),
    .misalign   (lane_misalign),
    .load_data  (load_data)
  );

  // A pending LLbit write in WB is newer than the committed register value.
  assign ll_eff     = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
  assign is_load    = is_load_op(aluop_i);
  assign is_mem     = is_load | is_store_op(aluop_i);
  assign misaligned = |lane_misalign;
  assign sc_fail    = (aluop_i == EXE_SC_OP) && !ll_eff;
  assign start      = (state_reg == IDLE) && is_mem && !misaligned && !sc_fail && !flush;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg    <= IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_sel_o   <= 4'b0000;
      dbus_wdata_o <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= REQ;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= lane_we;
            dbus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            dbus_sel_o   <= lane_sel;
            dbus_wdata_o <= lane_wdata;
          end
        end
        REQ: begin
          // Flush wins over a same-cycle ack: the access is abandoned.
          if (flush) begin
            state_reg  <= IDLE;
            dbus_req_o <= 1'b0;
          end else if (dbus_ack_i) begin
            state_reg  <= DONE;
            dbus_req_o <= 1'b0;
            rdata_q    <= dbus_rdata_i;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // EX/MEM is frozen while stalled, so results come from the live inputs
  // plus the captured read word.
  always_comb begin
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    misalign_o    = lane_misalign;
    stallreq_o    = 1'b0;
    if (rst == RST_ENABLE) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = ZERO_WORD;
      misalign_o = 2'b00;
    end else if (is_mem) begin
      wreg_o  = 1'b0;
      wdata_o = ZERO_WORD;
      case (state_reg)
        IDLE: begin
          if (misaligned) begin
            stallreq_o = 1'b0;
          end else if (sc_fail) begin
            // SC lost its reservation: report failure without touching the bus.
            wreg_o = WRITE_ENABLE;
          end else begin
            stallreq_o = start;
          end
        end
        REQ: stallreq_o = 1'b1;
        DONE: begin
          if (is_load) begin
            wreg_o  = wreg_i && !flush;
            wdata_o = load_data;
            if (aluop_i == EXE_LL_OP) begin
              LLbit_we_o    = !flush;
              LLbit_value_o = 1'b1;
            end
          end else if (aluop_i == EXE_SC_OP) begin
            wreg_o        = !flush;
            wdata_o       = 32'h0000_0001;
            LLbit_we_o    = !flush;
            LLbit_value_o = 1'b0;
          end
        end
        default: stallreq_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a
// randomized run checked against a behavioural reference model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam logic [7:0] OR_OP = 8'b0010_0101;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        LLbit_i;
  logic        wb_LLbit_we_i;
  logic        wb_LLbit_value_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        LLbit_we_o;
  logic        LLbit_value_o;
  logic [1:0]  misalign_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .LLbit_i(LLbit_i),
    .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o),
    .dbus_wdata_o(dbus_wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o), .misalign_o(misalign_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour of one instruction, derived from the ISA rules.
  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [1:0]  mis;
    logic        sc_fail;
    logic        access;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] result;
    logic        wreg_done;
    logic        ll_we;
    logic        ll_val;
  } exp_t;

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] reg2, input logic [31:0] rdata,
                                 input logic ll_eff);
    exp_t e;
    int a;
    logic [31:0] v;
    e = '0;
    a = int'(addr % 4);
    case (op)
      EXE_LB_OP, EXE_LBU_OP: begin
        e.is_mem = 1'b1;
        e.sel = 4'(1 << (3 - a));
        v = (rdata >> (8 * (3 - a))) & 32'hFF;
        if (op == EXE_LB_OP && v >= 32'h80) v = v + 32'hFFFF_FF00;
        e.result = v;
        e.wreg_done = 1'b1;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        e.is_mem = 1'b1;
        e.mis = (addr % 2 != 0) ? 2'b10 : 2'b00;
        e.sel = (a >= 2) ? 4'b0011 : 4'b1100;
        v = (rdata >> ((a >= 2) ? 0 : 16)) & 32'hFFFF;
        if (op == EXE_LH_OP && v >= 32'h8000) v = v + 32'hFFFF_0000;
        e.result = v;
        e.wreg_done = 1'b1;
      end
      EXE_LW_OP, EXE_LL_OP: begin
        e.is_mem = 1'b1;
        e.mis = (a != 0) ? 2'b10 : 2'b00;
        e.sel = 4'hF;
        e.result = rdata;
        e.wreg_done = 1'b1;
        if (op == EXE_LL_OP) begin e.ll_we = 1'b1; e.ll_val = 1'b1; end
      end
      EXE_SB_OP: begin
        e.is_mem = 1'b1; e.we = 1'b1;
        e.sel = 4'(1 << (3 - a));
        e.bwdata = (reg2 & 32'hFF) * 32'h0101_0101;
      end
      EXE_SH_OP: begin
        e.is_mem = 1'b1; e.we = 1'b1;
        e.mis = (addr % 2 != 0) ? 2'b01 : 2'b00;
        e.sel = (a >= 2) ? 4'b0011 : 4'b1100;
        e.bwdata = (reg2 & 32'hFFFF) * 32'h0001_0001;
      end
      EXE_SW_OP, EXE_SC_OP: begin
        e.is_mem = 1'b1; e.we = 1'b1;
        e.mis = (a != 0) ? 2'b01 : 2'b00;
        e.sel = 4'hF;
        e.bwdata = reg2;
        if (op == EXE_SC_OP) begin
          e.sc_fail = (e.mis == 2'b00) && !ll_eff;
          e.result = 32'd1; e.wreg_done = 1'b1; e.ll_we = 1'b1; e.ll_val = 1'b0;
        end
      end
      default: ;
    endcase
    e.access = e.is_mem && (e.mis == 2'b00) && !e.sc_fail;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; aluop_i = OR_OP; mem_addr_i = 32'h0; reg2_i = 32'h0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; LLbit_i = 1'b0;
    wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0; dbus_rdata_i = 32'h0; dbus_ack_i = 1'b0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(EXE_LW_OP, 32'h4002, 32'h1234);
    #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stallreq_o); end
    checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL rst_wreg: got %b want 0", wreg_o); end
    checks++; if (wd_o !== 5'd0) begin errors++; $display("FAIL rst_wd: got %h want 0", wd_o); end
    checks++; if (misalign_o !== 2'b00) begin errors++; $display("FAIL rst_misalign: got %b want 00", misalign_o); end
    checks++; if (dbus_req_o !== 1'b0 || dbus_sel_o !== 4'h0 || dbus_addr_o !== 32'h0)
      begin errors++; $display("FAIL rst_bus: got req=%b sel=%h addr=%h want 0", dbus_req_o, dbus_sel_o, dbus_addr_o); end
    step();
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_lb();
    set_op(EXE_LB_OP, 32'h1001, 32'h0);
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL lb_stall_c0: got %b want 1", stallreq_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL lb_req_c0: got %b want 0", dbus_req_o); end
    step();
    checks++; if (dbus_req_o !== 1'b1 || dbus_we_o !== 1'b0) begin errors++; $display("FAIL lb_req_c1: got req=%b we=%b want 1/0", dbus_req_o, dbus_we_o); end
    checks++; if (dbus_sel_o !== 4'b0100) begin errors++; $display("FAIL lb_sel: got %b want 0100", dbus_sel_o); end
    checks++; if (dbus_addr_o !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", dbus_addr_o); end
    checks++; if (stallreq_o !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL lb_stall_c1: got stall=%b wreg=%b want 1/0", stallreq_o, wreg_o); end
    step();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h12F4_5678;
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL lb_stall_c2: got %b want 1", stallreq_o); end
    step();
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
    #1;
    checks++; if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0) begin errors++; $display("FAIL lb_done_stall: got stall=%b req=%b want 0/0", stallreq_o, dbus_req_o); end
    checks++; if (wreg_o !== 1'b1 || wdata_o !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb_done_data: got wreg=%b wdata=%h want 1/fffffff4", wreg_o, wdata_o); end
    step();
    idle_inputs();
    $display("txn lb addr=00001000 done");
  endtask

  task automatic test_sh();
    set_op(EXE_SH_OP, 32'h2002, 32'h0000_ABCD);
    wreg_i = 1'b0;
    step();
    checks++; if (dbus_req_o !== 1'b1 || dbus_we_o !== 1'b1) begin errors++; $display("FAIL sh_req: got req=%b we=%b want 1/1", dbus_req_o, dbus_we_o); end
    checks++; if (dbus_sel_o !== 4'b0011) begin errors++; $display("FAIL sh_sel: got %b want 0011", dbus_sel_o); end
    checks++; if (dbus_wdata_o !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", dbus_wdata_o); end
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    #1;
    checks++; if (wreg_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL sh_done: got wreg=%b stall=%b want 0/0", wreg_o, stallreq_o); end
    step();
    idle_inputs();
    $display("txn sh addr=00002002 done");
  endtask

  task automatic test_ll();
    set_op(EXE_LL_OP, 32'h3000, 32'h0);
    step();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    step();
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
    #1;
    checks++; if (wdata_o !== 32'hDEAD_BEEF || wreg_o !== 1'b1) begin errors++; $display("FAIL ll_data: got wdata=%h wreg=%b want deadbeef/1", wdata_o, wreg_o); end
    checks++; if (LLbit_we_o !== 1'b1 || LLbit_value_o !== 1'b1) begin errors++; $display("FAIL ll_llbit: got we=%b val=%b want 1/1", LLbit_we_o, LLbit_value_o); end
    step();
    idle_inputs();
    #1;
    checks++; if (LLbit_we_o !== 1'b0) begin errors++; $display("FAIL ll_after: got LLbit_we=%b want 0", LLbit_we_o); end
    $display("txn ll addr=00003000 done");
  endtask

  task automatic test_sc();
    set_op(EXE_SC_OP, 32'h5000, 32'h7777_0001);
    LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL sc_ok_stall: got %b want 1", stallreq_o); end
    step();
    checks++; if (dbus_req_o !== 1'b1 || dbus_we_o !== 1'b1) begin errors++; $display("FAIL sc_ok_req: got req=%b we=%b want 1/1", dbus_req_o, dbus_we_o); end
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    #1;
    checks++; if (wdata_o !== 32'd1 || wreg_o !== 1'b1) begin errors++; $display("FAIL sc_ok_data: got wdata=%h wreg=%b want 1/1", wdata_o, wreg_o); end
    checks++; if (LLbit_we_o !== 1'b1 || LLbit_value_o !== 1'b0) begin errors++; $display("FAIL sc_ok_llbit: got we=%b val=%b want 1/0", LLbit_we_o, LLbit_value_o); end
    step();
    wb_LLbit_value_i = 1'b0;
    #1;
    checks++; if (stallreq_o !== 1'b0 || wreg_o !== 1'b1 || wdata_o !== 32'd0) begin errors++; $display("FAIL sc_fail_out: got stall=%b wreg=%b wdata=%h want 0/1/0", stallreq_o, wreg_o, wdata_o); end
    checks++; if (LLbit_we_o !== 1'b0) begin errors++; $display("FAIL sc_fail_llbit: got %b want 0", LLbit_we_o); end
    step();
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL sc_fail_req: got %b want 0", dbus_req_o); end
    idle_inputs();
    $display("txn sc addr=00005000 done");
  endtask

  task automatic test_misalign();
    set_op(EXE_LW_OP, 32'h4002, 32'h0);
    #1;
    checks++; if (misalign_o !== 2'b10) begin errors++; $display("FAIL mis_code: got %b want 10", misalign_o); end
    checks++; if (stallreq_o !== 1'b0 || wreg_o !== 1'b0) begin errors++; $display("FAIL mis_out: got stall=%b wreg=%b want 0/0", stallreq_o, wreg_o); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL mis_req%0d: got %b want 0", c, dbus_req_o); end
    end
    idle_inputs();
    $display("txn lw misaligned addr=00004002 done");
  endtask

  task automatic test_flush_ack();
    logic [7:0] op;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? EXE_SW_OP : EXE_LW_OP;
      set_op(op, 32'h6000, 32'h0BAD_F00D);
      step();
      flush = 1'b1; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
      step();
      flush = 1'b0; dbus_ack_i = 1'b0;
      #1;
      // Back in IDLE, the still-present op must start a fresh request.
      checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL flush_req%0d: got %b want 0", k, dbus_req_o); end
      checks++; if (stallreq_o !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL flush_state%0d: got stall=%b wreg=%b want 1/0", k, stallreq_o, wreg_o); end
      flush = 1'b1;
      step();
      idle_inputs();
      $display("txn flush op=%h addr=00006000 done", op);
    end
  endtask

  task automatic test_rst_mid_req();
    set_op(EXE_LW_OP, 32'h7000, 32'h0);
    step();
    checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL rstreq_req: got %b want 1", dbus_req_o); end
    rst = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b0 || wreg_o !== 1'b0) begin errors++; $display("FAIL rstreq_comb: got stall=%b wreg=%b want 0/0", stallreq_o, wreg_o); end
    step();
    checks++; if (dbus_req_o !== 1'b0 || dbus_addr_o !== 32'h0 || dbus_sel_o !== 4'h0)
      begin errors++; $display("FAIL rstreq_bus: got req=%b addr=%h sel=%h want 0", dbus_req_o, dbus_addr_o, dbus_sel_o); end
    rst = 1'b0;
    idle_inputs();
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    #1;
    checks++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL rstreq_after: got req=%b stall=%b want 0/0", dbus_req_o, stallreq_o); end
    $display("txn reset during req done");
  endtask

  task automatic test_random(input int n);
    logic [7:0]  ops [12];
    logic [7:0]  op;
    logic [31:0] addr, reg2, rdata, wdat;
    logic [4:0]  wd;
    logic        ll_eff;
    int          delay;
    exp_t        e;
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP, OR_OP, OR_OP};
    for (int k = 0; k < n; k++) begin
      op = ops[$urandom_range(0, 11)];
      addr = $urandom; reg2 = $urandom; rdata = $urandom; wdat = $urandom;
      wd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: addr[1:0] = 2'b00;
        1: addr[0] = 1'b0;
        default: ;
      endcase
      LLbit_i = 1'($urandom_range(0, 1));
      wb_LLbit_we_i = 1'($urandom_range(0, 1));
      wb_LLbit_value_i = 1'($urandom_range(0, 1));
      ll_eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
      delay = $urandom_range(0, 3);
      e = model(op, addr, reg2, rdata, ll_eff);
      aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = 1'b1; wdata_i = wdat;
      #1;
      $display("txn %0d op=%h addr=%h delay=%0d access=%0b", k, op, addr, delay, e.access);
      if (!e.is_mem) begin
        checks++; if (wreg_o !== 1'b1 || wdata_o !== wdat || wd_o !== wd)
          begin errors++; $display("FAIL rnd_pass%0d: got wreg=%b wdata=%h wd=%h want 1/%h/%h", k, wreg_o, wdata_o, wd_o, wdat, wd); end
        checks++; if (stallreq_o !== 1'b0 || LLbit_we_o !== 1'b0 || misalign_o !== 2'b00)
          begin errors++; $display("FAIL rnd_pass_ctl%0d: got stall=%b llwe=%b mis=%b want 0/0/00", k, stallreq_o, LLbit_we_o, misalign_o); end
        step();
      end else if (!e.access) begin
        checks++; if (misalign_o !== e.mis) begin errors++; $display("FAIL rnd_mis%0d: got %b want %b", k, misalign_o, e.mis); end
        checks++; if (stallreq_o !== 1'b0 || wreg_o !== e.sc_fail || LLbit_we_o !== 1'b0)
          begin errors++; $display("FAIL rnd_noacc%0d: got stall=%b wreg=%b llwe=%b want 0/%b/0", k, stallreq_o, wreg_o, LLbit_we_o, e.sc_fail); end
        if (e.sc_fail) begin
          checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL rnd_scfail%0d: got %h want 0", k, wdata_o); end
        end
        dbus_ack_i = 1'b1;  // stray ack in IDLE must be ignored
        step();
        dbus_ack_i = 1'b0;
        #1;
        checks++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0)
          begin errors++; $display("FAIL rnd_noreq%0d: got req=%b stall=%b want 0/0", k, dbus_req_o, stallreq_o); end
        step();
      end else begin
        checks++; if (stallreq_o !== 1'b1 || misalign_o !== 2'b00 || wreg_o !== 1'b0)
          begin errors++; $display("FAIL rnd_start%0d: got stall=%b mis=%b wreg=%b want 1/00/0", k, stallreq_o, misalign_o, wreg_o); end
        step();
        for (int c = 0; c <= delay; c++) begin
          if (c == delay) begin dbus_ack_i = 1'b1; dbus_rdata_i = rdata; end
          #1;
          checks++; if (dbus_req_o !== 1'b1 || dbus_we_o !== e.we || dbus_sel_o !== e.sel || dbus_addr_o !== (addr & 32'hFFFF_FFFC))
            begin errors++; $display("FAIL rnd_bus%0d: got req=%b we=%b sel=%b addr=%h want 1/%b/%b/%h", k, dbus_req_o, dbus_we_o, dbus_sel_o, dbus_addr_o, e.we, e.sel, addr & 32'hFFFF_FFFC); end
          if (e.we) begin
            checks++; if (dbus_wdata_o !== e.bwdata) begin errors++; $display("FAIL rnd_wdata%0d: got %h want %h", k, dbus_wdata_o, e.bwdata); end
          end
          checks++; if (stallreq_o !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL rnd_wait%0d: got stall=%b wreg=%b want 1/0", k, stallreq_o, wreg_o); end
          step();
          dbus_ack_i = 1'b0;
          dbus_rdata_i = $urandom;
        end
        #1;
        checks++; if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0) begin errors++; $display("FAIL rnd_done_ctl%0d: got stall=%b req=%b want 0/0", k, stallreq_o, dbus_req_o); end
        checks++; if (wreg_o !== e.wreg_done) begin errors++; $display("FAIL rnd_done_wreg%0d: got %b want %b", k, wreg_o, e.wreg_done); end
        if (e.wreg_done) begin
          checks++; if (wdata_o !== e.result) begin errors++; $display("FAIL rnd_done_data%0d: got %h want %h", k, wdata_o, e.result); end
        end
        checks++; if (LLbit_we_o !== e.ll_we) begin errors++; $display("FAIL rnd_done_llwe%0d: got %b want %b", k, LLbit_we_o, e.ll_we); end
        if (e.ll_we) begin
          checks++; if (LLbit_value_o !== e.ll_val) begin errors++; $display("FAIL rnd_done_llval%0d: got %b want %b", k, LLbit_value_o, e.ll_val); end
        end
        step();
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    test_reset();
    test_lb();
    test_sh();
    test_ll();
    test_sc();
    test_misalign();
    test_flush_ack();
    test_rst_mid_req();
    test_random(200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage data-memory access controller of the 5-stage MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It executes loads, stores and LL/SC against a req/ack data bus, and stalls the pipeline until the bus acknowledges. It produces the LLbit write request (LLbit_we_o/LLbit_value_o) consumed by the LLbit register. It also reads the committed LLbit, with a forwarding path from WB.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus / register width (fixed 32; byte lanes assume 4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset (`RstEnable`)
flush  in  1  pipeline flush; aborts any access in flight
aluop_i  in  8  operation code from EX/MEM (`EXE_*_OP` encodings)
mem_addr_i  in  32  effective address
reg2_i  in  32  store data (rt)
wd_i  in  5  destination register
wreg_i  in  1  destination write enable
wdata_i  in  32  ALU result for non-memory ops
LLbit_i  in  1  committed LLbit from the LLbit register
wb_LLbit_we_i  in  1  WB-stage pending LLbit write
wb_LLbit_value_i  in  1  WB-stage pending LLbit value
dbus_rdata_i  in  32  bus read data
dbus_ack_i  in  1  bus acknowledge, single-cycle pulse
dbus_req_o  out  1  bus request, held until ack
dbus_we_o  out  1  1 = write
dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_sel_o  out  4  byte-lane select, big-endian
dbus_wdata_o  out  32  lane-replicated store data
wd_o  out  5  to MEM/WB
wreg_o  out  1  to MEM/WB
wdata_o  out  32  to MEM/WB
LLbit_we_o  out  1  to MEM/WB → LLbit register
LLbit_value_o  out  1  to MEM/WB → LLbit register
misalign_o  out  2  {load_misalign, store_misalign}, to the exception logic
stallreq_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset: state=IDLE. All registered bus outputs are 0. While rst=1, every combinational output is forced to 0.
- Effective LLbit = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i.
- Non-memory aluop: wd/wreg/wdata pass through combinationally. No stall, no bus activity, LLbit_we_o=0.
- Alignment rules:
  - LH/LHU/SH fault when addr[0]=1.
  - LW/LL/SW/SC fault when addr[1:0]≠0.
  - On a fault: misalign_o set, wreg_o=0, no bus request, no stall, LLbit_we_o=0.
- SC with effective LLbit=0: no bus access, no stall. wreg_o=1, wdata_o=0, LLbit_we_o=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Transition: a valid, aligned memory op with flush=0 (excluding failed SC) → REQ.
  - On that transition, register addr/sel/wdata/we into the bus outputs and drive stallreq_o=1 combinationally in the same cycle.
- REQ:
  - Outputs: dbus_req_o=1, stallreq_o=1.
  - dbus_ack_i=1 → capture dbus_rdata_i into rdata_q, deassert req, go DONE.
  - flush=1 → IDLE with req deasserted; flush has priority over a same-cycle ack.
- DONE:
  - Outputs: stallreq_o=0; results presented for exactly one cycle, then → IDLE.
  - A flush in DONE suppresses wreg_o and LLbit_we_o.
- EX/MEM inputs are stable while stallreq_o=1, so outputs are derived from the current inputs plus rdata_q.
- Load data (big-endian) is selected from rdata_q:
  - LB/LBU: byte select by addr[1:0]; 00→[31:24] … 11→[7:0]; sign- or zero-extend.
  - LH/LHU: addr[1]=0→[31:16], 1→[15:0]; sign- or zero-extend.
  - LW/LL: full word.
- Store lanes:
  - SB: sel = 1000>>addr[1:0]; data {4{b}}.
  - SH: sel = 1100 or 0011; data {2{h}}.
  - SW/SC: sel 1111.
- LL completion: wdata_o = load word, LLbit_we_o=1, LLbit_value_o=1.
- SC success: wdata_o=1, LLbit_we_o=1, LLbit_value_o=0.
- Load/store result outputs (wreg_o, LLbit_we_o) are asserted only in DONE; wreg_o is 0 for stores and SC-success writes rd=1.
- An ack arriving in IDLE or DONE is ignored.
- Reset mid-REQ: the next cycle is IDLE with req=0 and the access is discarded.

Decomposition:
- Shared defines (defines.v): `EXE_LB_OP`…`EXE_SC_OP` aluop codes, `RstEnable`, `WriteEnable`, `ZeroWord`, and FSM state localparams (IDLE/REQ/DONE).
- One combinational sub-module, mem_lane_align: maps aluop/addr/store data to sel/wdata/misalign, and maps rdata/addr to extended load data.
- The FSM, LLbit forwarding and output muxing stay in mem_access_ctrl.

Test Plan:
- LB addr 0x1001, rdata 0x12F4_5678, ack after 2 cycles → stallreq_o=1 for 3 cycles, sel 0100 requested, DONE wdata_o=0xFFFF_FFF4, wreg_o=1.
- SH addr 0x2002, reg2 0x0000_ABCD → dbus_we_o=1, sel 0011, wdata 0xABCD_ABCD; on ack, wreg_o=0 in DONE.
- LL addr 0x3000, rdata 0xDEAD_BEEF → wdata_o=0xDEAD_BEEF, LLbit_we_o=1, LLbit_value_o=1.
- SC with LLbit_i=0 but wb_LLbit_we_i=1/value=1 → bus write issued, wdata_o=1, LLbit_we_o=1 value 0. Repeat with wb_LLbit_we_i=1/value=0 → no req, no stall, wdata_o=0.
- LW addr 0x4002 → misalign_o=2'b10, dbus_req_o never 1, stallreq_o=0, wreg_o=0.
- SW in REQ with flush=1 and ack in the same cycle → next cycle IDLE, req=0, no DONE results. Also: rst=1 in REQ → IDLE, all outputs 0.
